deinterleaver_fsm: RTL and testbench

//  Receive-side counterpart of the turbo interleaver. Accepts one block of K

---
 rtl/deinterleaver_fsm.sv | 182 ++++++++++++++++++
 tb/tb_deinterleaver_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver_fsm.sv
// -----------------------------------------------------------------------------
// deinterleaver_fsm
// Receive-side QPP turbo deinterleaver. One block of K interleaved bits is
// written to a 1-bit RAM at address pi(j) = (F1*j + F2*j^2) mod K. The block is
// then read back in natural order 0..K-1. pi is generated incrementally, so no
// multipliers are needed:
//   pi(j+1) = pi(j) + g(j),  g(j+1) = g(j) + 2*F2,  both mod K.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   block_size  sampled with start: 1 -> K_LARGE, 0 -> K_SMALL
//   start       one-cycle pulse in IDLE that begins a block
//   data_valid  data_in is valid this cycle
//   data_in     interleaved input bit
//   in_ready    high in WRITE; a bit is accepted on data_valid & in_ready
//   out_valid   data_out carries a natural-order bit
//   data_out    deinterleaved output bit
//   done        one-cycle pulse together with the last out_valid
// -----------------------------------------------------------------------------
module deinterleaver_fsm #(
    parameter int unsigned K_LARGE = 6144,
    parameter int unsigned K_SMALL = 1056,
    parameter int unsigned F1_L    = 263,
    parameter int unsigned F2_L    = 480,
    parameter int unsigned F1_S    = 17,
    parameter int unsigned F2_S    = 66,
    parameter int unsigned CW      = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic block_size,
    input  logic start,
    input  logic data_valid,
    input  logic data_in,
    output logic in_ready,
    output logic out_valid,
    output logic data_out,
    output logic done
);

    // Per-size constants, reduced mod K at elaboration time.
    localparam int unsigned G0_L     = (F1_L + F2_L) % K_LARGE;
    localparam int unsigned G0_S     = (F1_S + F2_S) % K_SMALL;
    localparam int unsigned TWO_F2_L = (2 * F2_L) % K_LARGE;
    localparam int unsigned TWO_F2_S = (2 * F2_S) % K_SMALL;

    localparam logic [CW-1:0] K_L_W      = CW'(K_LARGE);
    localparam logic [CW-1:0] K_S_W      = CW'(K_SMALL);
    localparam logic [CW-1:0] G0_L_W     = CW'(G0_L);
    localparam logic [CW-1:0] G0_S_W     = CW'(G0_S);
    localparam logic [CW-1:0] TWO_F2_L_W = CW'(TWO_F2_L);
    localparam logic [CW-1:0] TWO_F2_S_W = CW'(TWO_F2_S);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            big;
    logic [CW-1:0]   w_cnt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   pi;
    logic [CW-1:0]   g;

    logic [CW-1:0]   k_c;
    logic [CW-1:0]   k_last_c;
    logic [CW-1:0]   two_f2_c;
    logic [CW-1:0]   g0_c;
    logic            w_last_c;
    logic            r_last_c;
    logic [CW:0]     pi_sum_c;
    logic [CW:0]     g_sum_c;
    logic [CW-1:0]   pi_nxt_c;
    logic [CW-1:0]   g_nxt_c;

    logic            mem [K_LARGE];

    // Block-length dependent constants and end-of-phase detection.
    always_comb begin
        k_c      = big ? K_L_W : K_S_W;
        two_f2_c = big ? TWO_F2_L_W : TWO_F2_S_W;
        g0_c     = block_size ? G0_L_W : G0_S_W;
        k_last_c = k_c - CW'(1);
        w_last_c = (w_cnt == k_last_c);
        r_last_c = (r_cnt == k_last_c);
    end

    // Modular address step: both operands are < K, so one conditional
    // subtract keeps the result in range. Sums carry one extra bit.
    always_comb begin
        pi_sum_c = {1'b0, pi} + {1'b0, g};
        g_sum_c  = {1'b0, g} + {1'b0, two_f2_c};
        pi_nxt_c = (pi_sum_c >= {1'b0, k_c}) ? CW'(pi_sum_c - {1'b0, k_c}) : CW'(pi_sum_c);
        g_nxt_c  = (g_sum_c  >= {1'b0, k_c}) ? CW'(g_sum_c  - {1'b0, k_c}) : CW'(g_sum_c);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WRITE;
            S_WRITE: if (data_valid && w_last_c) state_nxt = S_READ;
            S_READ:  if (r_last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters and permutation generator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            big   <= 1'b0;
            w_cnt <= '0;
            r_cnt <= '0;
            pi    <= '0;
            g     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        big   <= block_size;
                        w_cnt <= '0;
                        pi    <= '0;
                        g     <= g0_c;
                    end
                end
                S_WRITE: begin
                    if (data_valid) begin
                        w_cnt <= w_cnt + CW'(1);
                        pi    <= pi_nxt_c;
                        g     <= g_nxt_c;
                        if (w_last_c) r_cnt <= '0;
                    end
                end
                S_READ: begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Bit RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (state == S_WRITE && data_valid) begin
            mem[pi] <= data_in;
        end
    end

    // Registered outputs; the synchronous RAM read lands in data_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            data_out  <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == S_WRITE);
            out_valid <= (state == S_READ);
            done      <= (state == S_READ) && r_last_c;
            if (state == S_READ) begin
                data_out <= mem[r_cnt];
            end
        end
    end

endmodule

// File: tb/tb_deinterleaver_fsm.sv
module tb_deinterleaver_fsm;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic block_size = 1'b0;
    logic start = 1'b0;
    logic data_valid = 1'b0;
    logic data_in = 1'b0;
    logic in_ready;
    logic out_valid;
    logic data_out;
    logic done;

    int errors = 0;
    int checks = 0;

    bit in_bits[$];
    bit ref_bits[$];
    bit out_bits[$];
    bit saved[$];
    int pi_seen[$];
    int done_idx;
    int n_done;
    int lat;
    bit gap;
    bit wr_ok;

    deinterleaver_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .block_size(block_size),
        .start     (start),
        .data_valid(data_valid),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    // QPP permutation straight from its closed form.
    function automatic int qpp(input int k, input int j);
        longint unsigned f1, f2, jj;
        f1 = (k == 6144) ? 263 : 17;
        f2 = (k == 6144) ? 480 : 66;
        jj = longint'(j);
        return int'((f1 * jj + f2 * jj * jj) % longint'(k));
    endfunction

    // Builds the interleaved input and the natural-order reference.
    task automatic make_block(input int k, input bit onehot);
        in_bits.delete();
        ref_bits.delete();
        if (onehot) begin
            for (int j = 0; j < k; j++) in_bits.push_back(j == 1);
            for (int n = 0; n < k; n++) ref_bits.push_back(1'b0);
            for (int j = 0; j < k; j++) ref_bits[qpp(k, j)] = in_bits[j];
        end else begin
            for (int n = 0; n < k; n++) ref_bits.push_back(1'($urandom));
            for (int j = 0; j < k; j++) in_bits.push_back(ref_bits[qpp(k, j)]);
        end
    endtask

    function automatic int count_diff();
        int n = 0;
        if (out_bits.size() != ref_bits.size()) return -1;
        foreach (ref_bits[i]) if (out_bits[i] !== ref_bits[i]) n++;
        return n;
    endfunction

    // Drives one block from an IDLE negedge and captures the output stream.
    // Returns at the negedge of the IDLE cycle following done.
    task automatic run_block(input bit big, input bit stray, input int vpct);
        int  k;
        int  j;
        int  cyc;
        bit  acc;
        bit  seen;
        k = big ? 6144 : 1056;
        j = 0;
        cyc = 0;
        out_bits.delete();
        pi_seen.delete();
        done_idx = -1;
        n_done = 0;
        lat = 0;
        gap = 1'b0;
        block_size = big;
        start = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (j < k && cyc < 8 * k) begin
            start = stray ? ($urandom_range(0, 3) == 0) : 1'b0;
            data_valid = ($urandom_range(0, 99) < vpct);
            data_in = data_valid ? in_bits[j] : 1'($urandom);
            acc = data_valid && in_ready;
            if (acc) pi_seen.push_back(int'(dut.pi));
            @(negedge clk);
            if (acc) j++;
            cyc++;
        end
        wr_ok = (j == k);
        start = 1'b0;
        data_valid = 1'b0;
        seen = 1'b0;
        cyc = 0;
        while (cyc < 2 * k + 20) begin
            if (done) n_done++;
            if (out_valid) begin
                seen = 1'b1;
                out_bits.push_back(data_out);
                if (done) begin
                    done_idx = out_bits.size() - 1;
                    start = 1'b0;
                    data_valid = 1'b0;
                    @(negedge clk);
                    break;
                end
            end else if (!seen) begin
                lat++;
            end else begin
                gap = 1'b1;
            end
            start = stray ? ($urandom_range(0, 3) == 0) : 1'b0;
            data_valid = stray ? 1'($urandom) : 1'b0;
            data_in = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, data_out, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {in_ready, out_valid, data_out, done});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 000", {in_ready, out_valid, done});
        end
    endtask

    task automatic test_small_onehot();
        int ones = 0;
        int d;
        make_block(1056, 1'b1);
        run_block(1'b0, 1'b0, 100);
        for (int i = 0; i < 4; i++) begin
            int got;
            got = (i < pi_seen.size()) ? pi_seen[i] : -1;
            checks++;
            if (got !== qpp(1056, i)) begin
                errors++;
                $display("FAIL small_pi%0d: got %0d expected %0d", i, got, qpp(1056, i));
            end
        end
        checks++;
        if (!wr_ok) begin errors++; $display("FAIL small_write: got %0d accepted expected 1056", pi_seen.size()); end
        checks++;
        if (out_bits.size() != 1056) begin errors++; $display("FAIL small_count: got %0d expected 1056", out_bits.size()); end
        foreach (out_bits[i]) ones += out_bits[i];
        checks++;
        if (ones != 1 || out_bits.size() < 84 || out_bits[83] !== 1'b1) begin
            errors++;
            $display("FAIL small_onehot: got %0d ones expected a single one at index 83", ones);
        end
        d = count_diff();
        checks++;
        if (d != 0) begin errors++; $display("FAIL small_data: got %0d mismatches expected 0", d); end
        checks++;
        if (done_idx != 1055 || n_done != 1) begin
            errors++;
            $display("FAIL small_done: got idx %0d pulses %0d expected idx 1055 pulses 1", done_idx, n_done);
        end
        checks++;
        if (lat != 1 || gap) begin errors++; $display("FAIL small_timing: got lat %0d gap %0d expected lat 1 gap 0", lat, gap); end
    endtask

    task automatic test_large_random();
        int d;
        int got;
        make_block(6144, 1'b0);
        run_block(1'b1, 1'b0, 100);
        got = (pi_seen.size() > 2) ? pi_seen[2] : -1;
        checks++;
        if (got !== qpp(6144, 2)) begin errors++; $display("FAIL large_pi2: got %0d expected %0d", got, qpp(6144, 2)); end
        d = count_diff();
        checks++;
        if (!wr_ok || d != 0) begin errors++; $display("FAIL large_data: got wr_ok %0d diff %0d expected 1 0", wr_ok, d); end
        checks++;
        if (done_idx != 6143 || n_done != 1 || gap || lat != 1) begin
            errors++;
            $display("FAIL large_timing: got idx %0d pulses %0d gap %0d lat %0d expected 6143 1 0 1", done_idx, n_done, gap, lat);
        end
    endtask

    task automatic test_gaps();
        int d;
        int nd = 0;
        make_block(1056, 1'b0);
        run_block(1'b0, 1'b0, 100);
        saved = out_bits;
        run_block(1'b0, 1'b1, 50);
        if (saved.size() != out_bits.size()) nd = -1;
        else foreach (saved[i]) if (saved[i] !== out_bits[i]) nd++;
        checks++;
        if (nd != 0) begin errors++; $display("FAIL gaps_vs_gapfree: got %0d differences expected 0", nd); end
        d = count_diff();
        checks++;
        if (!wr_ok || d != 0) begin errors++; $display("FAIL gaps_data: got wr_ok %0d diff %0d expected 1 0", wr_ok, d); end
        checks++;
        if (done_idx != 1055 || n_done != 1 || gap) begin
            errors++;
            $display("FAIL gaps_done: got idx %0d pulses %0d gap %0d expected 1055 1 0", done_idx, n_done, gap);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        // Abort in WRITE.
        block_size = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_valid = 1'b1;
        repeat (100) begin
            data_in = 1'($urandom);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, data_out, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_write: got %b expected 0000", {in_ready, out_valid, data_out, done});
        end
        data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        // Abort in READ: out_valid must fall without waiting for a clock.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_valid = 1'b1;
        data_in = 1'b1;
        repeat (1056) @(negedge clk);
        data_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL read_active: got %b expected 1", out_valid); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, data_out, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_read: got %b expected 000", {out_valid, data_out, done});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        make_block(1056, 1'b0);
        run_block(1'b0, 1'b0, 100);
        d = count_diff();
        checks++;
        if (!wr_ok || d != 0 || done_idx != 1055) begin
            errors++;
            $display("FAIL after_reset_data: got wr_ok %0d diff %0d idx %0d expected 1 0 1055", wr_ok, d, done_idx);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        make_block(1056, 1'b0);
        run_block(1'b0, 1'b0, 100);
        d = count_diff();
        checks++;
        if (!wr_ok || d != 0 || done_idx != 1055 || gap) begin
            errors++;
            $display("FAIL b2b_first: got wr_ok %0d diff %0d idx %0d gap %0d expected 1 0 1055 0", wr_ok, d, done_idx, gap);
        end
        make_block(6144, 1'b0);
        run_block(1'b1, 1'b0, 100);
        d = count_diff();
        checks++;
        if (!wr_ok || d != 0 || done_idx != 6143 || gap) begin
            errors++;
            $display("FAIL b2b_second: got wr_ok %0d diff %0d idx %0d gap %0d expected 1 0 6143 0", wr_ok, d, done_idx, gap);
        end
        checks++;
        if ({out_valid, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", {out_valid, done}); end
    endtask

    initial begin
        test_reset();
        test_small_onehot();
        test_large_random();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
